video_gray_binary_pipe: RTL and testbench



---
 rtl/video_gray_binary_pipe_if.sv | 31 +++
 rtl/video_gray_binary_pipe.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_video_gray_binary_pipe.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_gray_binary_pipe_if.sv
// Video stream bundle for video_gray_binary_pipe: input pixel stream and
// delay-matched output stream. master drives the i_* side, slave is the pipe.
interface video_gray_binary_pipe_if #(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned COORD_W = 12
);
  logic               i_hs;
  logic               i_vs;
  logic               i_de;
  logic [COORD_W-1:0] i_x;
  logic [COORD_W-1:0] i_y;
  logic [IN_W-1:0]    i_data;

  logic               o_hs;
  logic               o_vs;
  logic               o_de;
  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic [23:0]        o_data;
  logic               th_flag;

  modport master (
    output i_hs, i_vs, i_de, i_x, i_y, i_data,
    input  o_hs, o_vs, o_de, o_x, o_y, o_data, th_flag
  );

  modport slave (
    input  i_hs, i_vs, i_de, i_x, i_y, i_data,
    output o_hs, o_vs, o_de, o_x, o_y, o_data, th_flag
  );
endinterface

// File: rtl/video_gray_binary_pipe.sv
// Three-stage RGB -> luma -> RGB/grey/binary/inverted-binary pixel pipe with key-driven
// threshold and mode, applied at vsync rising edges. Define AUTO_TH_EN for min/max auto threshold.
module video_gray_binary_pipe #(
  parameter int unsigned R_BITS     = 5,
  parameter int unsigned G_BITS     = 6,
  parameter int unsigned B_BITS     = 5,
  parameter int unsigned COORD_W    = 12,
  parameter logic [7:0]  TH_INIT    = 8'd40,
  parameter logic [7:0]  TH_STEP    = 8'd5,
  parameter int unsigned WIN_X0     = 30,
  parameter int unsigned WIN_X1     = 450,
  parameter int unsigned WIN_Y0     = 50,
  parameter int unsigned WIN_Y1     = 220,
  parameter logic [23:0] MASK_COLOR = 24'hAAAAAA
) (
  input  logic                           clk,
  input  logic                           rst,
  video_gray_binary_pipe_if.slave        vid,
  input  logic                           key_mode,
  input  logic                           key_up,
  input  logic                           key_down,
  input  logic                           auto_en,
  output logic [1:0]                     o_mode,
  output logic [7:0]                     o_threshold
);

  localparam int unsigned DATA_W = R_BITS + G_BITS + B_BITS;

  // ---------------------------------------------------------------------------
  // Stage 1: split fields and expand each to 8 bits
  // ---------------------------------------------------------------------------
  logic [R_BITS-1:0] r_raw;
  logic [G_BITS-1:0] g_raw;
  logic [B_BITS-1:0] b_raw;
  logic [7:0]        r8_d, g8_d, b8_d;

  assign r_raw = vid.i_data[DATA_W-1 -: R_BITS];
  assign g_raw = vid.i_data[B_BITS +: G_BITS];
  assign b_raw = vid.i_data[0 +: B_BITS];

  // Appending 8 zeros then dropping the field width left-justifies narrow fields
  // and keeps only the top 8 bits of wide ones.
  always_comb begin
    r8_d = 8'(({r_raw, 8'h00}) >> R_BITS);
    g8_d = 8'(({g_raw, 8'h00}) >> G_BITS);
    b8_d = 8'(({b_raw, 8'h00}) >> B_BITS);
  end

  logic [7:0]         s1_r_q, s1_g_q, s1_b_q;
  logic               s1_hs_q, s1_vs_q, s1_de_q;
  logic [COORD_W-1:0] s1_x_q, s1_y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r_q  <= '0;
      s1_g_q  <= '0;
      s1_b_q  <= '0;
      s1_hs_q <= 1'b0;
      s1_vs_q <= 1'b0;
      s1_de_q <= 1'b0;
      s1_x_q  <= '0;
      s1_y_q  <= '0;
    end else begin
      s1_r_q  <= r8_d;
      s1_g_q  <= g8_d;
      s1_b_q  <= b8_d;
      s1_hs_q <= vid.i_hs;
      s1_vs_q <= vid.i_vs;
      s1_de_q <= vid.i_de;
      s1_x_q  <= vid.i_x;
      s1_y_q  <= vid.i_y;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: luma
  // ---------------------------------------------------------------------------
  logic [15:0] y_sum;
  logic [7:0]  y_d;

  always_comb begin
    y_sum = 16'd77 * {8'd0, s1_r_q} + 16'd150 * {8'd0, s1_g_q} + 16'd29 * {8'd0, s1_b_q};
    y_d   = y_sum[15:8];
  end

  logic [23:0]        s2_rgb_q;
  logic [7:0]         s2_y_q;
  logic               s2_hs_q, s2_vs_q, s2_de_q;
  logic [COORD_W-1:0] s2_x_q, s2_y_coord_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_rgb_q     <= '0;
      s2_y_q       <= '0;
      s2_hs_q      <= 1'b0;
      s2_vs_q      <= 1'b0;
      s2_de_q      <= 1'b0;
      s2_x_q       <= '0;
      s2_y_coord_q <= '0;
    end else begin
      s2_rgb_q     <= {s1_r_q, s1_g_q, s1_b_q};
      s2_y_q       <= y_d;
      s2_hs_q      <= s1_hs_q;
      s2_vs_q      <= s1_vs_q;
      s2_de_q      <= s1_de_q;
      s2_x_q       <= s1_x_q;
      s2_y_coord_q <= s1_y_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Key edge detection, pending/active threshold and mode
  // ---------------------------------------------------------------------------
  logic       key_mode_q, key_up_q, key_down_q, vs_prev_q;
  logic       mode_rise, up_rise, down_rise, vs_rise;
  logic [7:0] th_pend_q, th_pend_d, th_act_q, th_act_d;
  logic [1:0] mode_pend_q, mode_pend_d, mode_act_q, mode_act_d;
  logic [8:0] th_up_sum;

  assign mode_rise = key_mode & ~key_mode_q;
  assign up_rise   = key_up & ~key_up_q;
  assign down_rise = key_down & ~key_down_q;
  assign vs_rise   = vid.i_vs & ~vs_prev_q;
  assign th_up_sum = {1'b0, th_pend_q} + {1'b0, TH_STEP};

`ifdef AUTO_TH_EN
  logic [7:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic       seen_q, seen_d;
  logic [8:0] auto_sum;
  logic [7:0] auto_th;

  assign auto_sum = {1'b0, y_min_q} + {1'b0, y_max_q};
  assign auto_th  = auto_sum[8:1];

  // Trackers watch stage-2 luma; a vs edge restarts them for the new frame.
  always_comb begin
    y_min_d = y_min_q;
    y_max_d = y_max_q;
    seen_d  = seen_q;
    if (vs_rise) begin
      y_min_d = 8'hFF;
      y_max_d = 8'h00;
      seen_d  = 1'b0;
    end else if (s2_de_q) begin
      if (s2_y_q < y_min_q) y_min_d = s2_y_q;
      if (s2_y_q > y_max_q) y_max_d = s2_y_q;
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_min_q <= 8'hFF;
      y_max_q <= 8'h00;
      seen_q  <= 1'b0;
    end else begin
      y_min_q <= y_min_d;
      y_max_q <= y_max_d;
      seen_q  <= seen_d;
    end
  end
`else
  logic unused_auto_en;
  assign unused_auto_en = auto_en;
`endif

  always_comb begin
    th_pend_d   = th_pend_q;
    th_act_d    = th_act_q;
    mode_pend_d = mode_pend_q;
    mode_act_d  = mode_act_q;

    if (up_rise && !down_rise) begin
      th_pend_d = (th_up_sum > 9'd255) ? 8'hFF : th_up_sum[7:0];
    end else if (down_rise && !up_rise) begin
      th_pend_d = (th_pend_q < TH_STEP) ? 8'h00 : th_pend_q - TH_STEP;
    end
    if (mode_rise) begin
      mode_pend_d = mode_pend_q + 2'd1;
    end

    // Active values take the pre-edge pending values, so a key hit on the
    // boundary cycle only lands in the following frame.
    if (vs_rise) begin
      th_act_d   = th_pend_q;
      mode_act_d = mode_pend_q;
`ifdef AUTO_TH_EN
      if (auto_en && seen_q) begin
        th_act_d  = auto_th;
        th_pend_d = auto_th;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_mode_q  <= 1'b0;
      key_up_q    <= 1'b0;
      key_down_q  <= 1'b0;
      vs_prev_q   <= 1'b0;
      th_pend_q   <= TH_INIT;
      th_act_q    <= TH_INIT;
      mode_pend_q <= 2'd0;
      mode_act_q  <= 2'd0;
    end else begin
      key_mode_q  <= key_mode;
      key_up_q    <= key_up;
      key_down_q  <= key_down;
      vs_prev_q   <= vid.i_vs;
      th_pend_q   <= th_pend_d;
      th_act_q    <= th_act_d;
      mode_pend_q <= mode_pend_d;
      mode_act_q  <= mode_act_d;
    end
  end

  assign o_mode      = mode_act_q;
  assign o_threshold = th_act_q;

  // ---------------------------------------------------------------------------
  // Stage 3: mode mux, window mask, blanking
  // ---------------------------------------------------------------------------
  logic        bin_hi, masked, flag_d;
  logic [23:0] pix_d;

  always_comb begin
    bin_hi = (s2_y_q >= th_act_q);
    masked = (s2_x_q <= COORD_W'(WIN_X0)) || (s2_x_q >= COORD_W'(WIN_X1)) ||
             (s2_y_coord_q <= COORD_W'(WIN_Y0)) || (s2_y_coord_q >= COORD_W'(WIN_Y1));
    pix_d  = '0;
    unique case (mode_act_q)
      2'd0:    pix_d = s2_rgb_q;
      2'd1:    pix_d = {3{s2_y_q}};
      2'd2:    pix_d = {24{bin_hi}};
      default: pix_d = {24{~bin_hi}};
    endcase
    if (mode_act_q[1] && masked) begin
      pix_d = MASK_COLOR;
    end
    flag_d = bin_hi;
    if (!s2_de_q) begin
      pix_d  = '0;
      flag_d = 1'b0;
    end
  end

  logic               o_hs_q, o_vs_q, o_de_q, th_flag_q;
  logic [COORD_W-1:0] o_x_q, o_y_q;
  logic [23:0]        o_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_hs_q    <= 1'b0;
      o_vs_q    <= 1'b0;
      o_de_q    <= 1'b0;
      o_x_q     <= '0;
      o_y_q     <= '0;
      o_data_q  <= '0;
      th_flag_q <= 1'b0;
    end else begin
      o_hs_q    <= s2_hs_q;
      o_vs_q    <= s2_vs_q;
      o_de_q    <= s2_de_q;
      o_x_q     <= s2_x_q;
      o_y_q     <= s2_y_coord_q;
      o_data_q  <= pix_d;
      th_flag_q <= flag_d;
    end
  end

  assign vid.o_hs    = o_hs_q;
  assign vid.o_vs    = o_vs_q;
  assign vid.o_de    = o_de_q;
  assign vid.o_x     = o_x_q;
  assign vid.o_y     = o_y_q;
  assign vid.o_data  = o_data_q;
  assign vid.th_flag = th_flag_q;

endmodule

// File: tb/tb_video_gray_binary_pipe.sv
// Scoreboard bench for video_gray_binary_pipe: stimulus pushes expected pixels,
// a monitor pops and compares each o_de pixel. AUTO_TH_EN enables the auto-threshold model.
module tb_video_gray_binary_pipe;

  localparam int WX0 = 30, WX1 = 450, WY0 = 50, WY1 = 220;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0, key_up = 1'b0, key_down = 1'b0, auto_en = 1'b0;
  logic [1:0] o_mode;
  logic [7:0] o_threshold;

  video_gray_binary_pipe_if #(.IN_W(16), .COORD_W(12)) vif ();

  video_gray_binary_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .vid        (vif),
    .key_mode   (key_mode),
    .key_up     (key_up),
    .key_down   (key_down),
    .auto_en    (auto_en),
    .o_mode     (o_mode),
    .o_threshold(o_threshold)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] data;
    logic        flag;
    logic        hs;
    logic [11:0] x;
    logic [11:0] y;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state, kept as plain integers
  int m_th_pend, m_th_act, m_mode_pend, m_mode_act;
  int m_min, m_max;
  bit m_seen;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int luma(input logic [15:0] d);
    int r8, g8, b8;
    r8 = int'(d[15:11]) * 8;
    g8 = int'(d[10:5]) * 4;
    b8 = int'(d[4:0]) * 8;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  function automatic logic [23:0] model_pixel(input logic [15:0] d, input int x, input int y);
    int  l;
    bit  bin;
    l = luma(d);
    case (m_mode_act)
      0: return {8'(int'(d[15:11]) * 8), 8'(int'(d[10:5]) * 4), 8'(int'(d[4:0]) * 8)};
      1: return {8'(l), 8'(l), 8'(l)};
      default: begin
        if (x <= WX0 || x >= WX1 || y <= WY0 || y >= WY1) return 24'hAAAAAA;
        bin = (m_mode_act == 2) ? (l >= m_th_act) : (l < m_th_act);
        return bin ? 24'hFFFFFF : 24'h000000;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_th_pend = 40; m_th_act = 40; m_mode_pend = 0; m_mode_act = 0;
    m_min = 255; m_max = 0; m_seen = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vif.i_de = 1'b0; vif.i_hs = 1'b0; vif.i_data = '0;
    end
  endtask

  task automatic send_px_exp(input logic [15:0] d, input int x, input int y,
                             input logic [23:0] ed, input logic ef);
    exp_t e;
    int   l;
    @(negedge clk);
    vif.i_de = 1'b1; vif.i_data = d; vif.i_x = 12'(x); vif.i_y = 12'(y);
    vif.i_hs = 1'($urandom_range(0, 1));
    e.data = ed; e.flag = ef; e.hs = vif.i_hs; e.x = 12'(x); e.y = 12'(y); e.cyc = cyc;
    sb.push_back(e);
    l = luma(d);
    if (l < m_min) m_min = l;
    if (l > m_max) m_max = l;
    m_seen = 1;
  endtask

  task automatic send_px(input logic [15:0] d, input int x, input int y);
    send_px_exp(d, x, y, model_pixel(d, x, y), 1'(luma(d) >= m_th_act));
  endtask

  task automatic press(input bit up, input bit down, input bit mode);
    @(negedge clk);
    vif.i_de = 1'b0;
    key_up = up; key_down = down; key_mode = mode;
    @(negedge clk);
    key_up = 1'b0; key_down = 1'b0; key_mode = 1'b0;
    if (mode) m_mode_pend = (m_mode_pend + 1) % 4;
    if (up && !down) m_th_pend = (m_th_pend + 5 > 255) ? 255 : m_th_pend + 5;
    if (down && !up) m_th_pend = (m_th_pend < 5) ? 0 : m_th_pend - 5;
  endtask

  task automatic vs_edge();
    idle(3);
    @(negedge clk);
    vif.i_vs = 1'b1;
    m_mode_act = m_mode_pend;
    m_th_act = m_th_pend;
`ifdef AUTO_TH_EN
    if (auto_en && m_seen) begin
      m_th_act = (m_min + m_max) / 2;
      m_th_pend = m_th_act;
    end
`endif
    m_min = 255; m_max = 0; m_seen = 0;
    @(negedge clk);
    @(negedge clk);
    vif.i_vs = 1'b0;
    check("vs_latency_early", vif.o_vs, 0);
    @(negedge clk);
    check("vs_latency", vif.o_vs, 1);
    idle(2);
    check("o_threshold", o_threshold, m_th_act);
    check("o_mode", o_mode, m_mode_act);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    vif.i_de = 1'b0; vif.i_vs = 1'b0; vif.i_hs = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_mode = 1'b0;
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", {vif.o_hs, vif.o_vs, vif.o_de, vif.th_flag, vif.o_data,
                            vif.o_x, vif.o_y}, 0);
    check("reset_threshold", o_threshold, 40);
    check("reset_mode", o_mode, 0);
    rst = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (vif.o_de === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel: got data %0h with empty scoreboard", vif.o_data);
        end else begin
          e = sb.pop_front();
          check("pix_data", {vif.o_data, vif.th_flag}, {e.data, e.flag});
          check("pix_sync", {vif.o_hs, vif.o_vs, vif.o_x, vif.o_y}, {e.hs, 1'b0, e.x, e.y});
          check("pix_latency", cyc - e.cyc, 3);
        end
      end else if (!rst) begin
        check("blank_zero", {vif.o_de, vif.o_data, vif.th_flag}, 0);
      end
    end
  end

  initial begin
    vif.i_hs = 1'b0; vif.i_vs = 1'b0; vif.i_de = 1'b0;
    vif.i_x = '0; vif.i_y = '0; vif.i_data = '0;
    model_reset();
    do_reset();

    // Mode 1 grey
    press(0, 0, 1);
    vs_edge();
    send_px_exp(16'hFFFF, 100, 100, 24'hFAFAFA, 1'b1);
    send_px_exp(16'hF800, 100, 100, 24'h4A4A4A, 1'b1);

    // Mode 2 binary with window mask
    press(0, 0, 1);
    vs_edge();
    send_px_exp(16'hF800, 100, 100, 24'hFFFFFF, 1'b1);
    send_px_exp(16'hF800, 30, 100, 24'hAAAAAA, 1'b1);
    send_px_exp(16'hF800, 100, 220, 24'hAAAAAA, 1'b1);
    idle(1);

    // Threshold to 75, active only from the next frame
    repeat (7) press(1, 0, 0);
    check("th_hold_midframe", o_threshold, 40);
    send_px_exp(16'hF800, 100, 100, 24'hFFFFFF, 1'b1);
    vs_edge();
    check("th_75", o_threshold, 75);
    send_px_exp(16'hF800, 100, 100, 24'h000000, 1'b0);

    // Mode 3 inverted binary
    press(0, 0, 1);
    vs_edge();
    send_px_exp(16'hF800, 31, 51, 24'hFFFFFF, 1'b0);

    // Fourth press wraps; held until the vs edge
    press(0, 0, 1);
    check("mode_hold_midframe", o_mode, 3);
    vs_edge();
    check("mode_wrap", o_mode, 0);

    // Randomised frames
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        case ($urandom_range(0, 3))
          0: press(1, 0, 0);
          1: press(0, 1, 0);
          2: press(0, 0, 1);
          default: press(1, 1, 0);
        endcase
      end
      auto_en = 1'($urandom_range(0, 1));
      vs_edge();
      for (int p = 0; p < 30; p++) begin
        send_px(16'($urandom), int'($urandom_range(0, 500)), int'($urandom_range(0, 300)));
      end
    end
    auto_en = 1'b0;

    // Saturation and edge-only key behaviour
    do_reset();
    repeat (43) press(1, 0, 0);
    vs_edge();
    check("th_sat_255", o_threshold, 255);
    press(1, 0, 0);
    vs_edge();
    check("th_stay_255", o_threshold, 255);
    repeat (60) press(0, 1, 0);
    vs_edge();
    check("th_sat_0", o_threshold, 0);
    @(negedge clk);
    key_up = 1'b1;
    repeat (100) @(negedge clk);
    key_up = 1'b0;
    m_th_pend = 5;
    vs_edge();
    check("th_held_once", o_threshold, 5);
    press(1, 1, 0);
    vs_edge();
    check("th_up_down", o_threshold, 5);

    // Reset mid-frame with pixels in flight
    press(0, 0, 1);
    for (int p = 0; p < 5; p++) send_px(16'($urandom), 100 + p, 100);
    do_reset();
    for (int p = 0; p < 8; p++) send_px(16'($urandom), 100 + p, 120);
    vs_edge();

`ifdef AUTO_TH_EN
    begin
      int d20, d200;
      d20 = -1; d200 = -1;
      for (int d = 0; d < 65536; d++) begin
        if (d20 < 0 && luma(16'(d)) == 20) d20 = d;
        if (d200 < 0 && luma(16'(d)) == 200) d200 = d;
      end
      check("auto_data_found", (d20 >= 0 && d200 >= 0), 1);
      auto_en = 1'b1;
      vs_edge();
      send_px(16'(d20), 100, 100);
      send_px(16'(d200), 101, 100);
      send_px(16'(d20), 102, 100);
      vs_edge();
      check("auto_th_110", o_threshold, 110);
      vs_edge();
      check("auto_no_de", o_threshold, 110);
      auto_en = 1'b0;
    end
`endif

    idle(6);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
